// File: rtl/wb_dsp_master_if.sv
// ---------------------------------------------------------------------------
// wb_dsp_master_if
//
// Single-transfer Wishbone B3 classic master for the DSP core. Each one-shot
// request from the DSP sequencer becomes one Wishbone cycle, with bounded
// reissue on rty, an optional no-response timeout, and a completion status.
//
// FSM states:
//   state  | meaning
//   IDLE   | no transfer; accepts req_start
//   BUS    | cyc/stb high, waiting for ack/err/rty or timeout
//   GAP    | cyc/stb low after rty, counting down before the reissue
//
// Ports:
//   wb_clk, wb_rst        clock, asynchronous active-high reset
//   wb_adr_o .. wb_bte_o  Wishbone master outputs (all registered)
//   wb_dat_i, wb_ack_i,
//   wb_err_i, wb_rty_i    Wishbone slave responses
//   req_start             one-cycle request strobe (ignored while busy)
//   req_we, req_adr,
//   req_dat, req_sel      request attributes, latched on req_start
//   req_busy              transfer in progress (state != IDLE)
//   req_done              one-cycle completion pulse
//   req_rdata             data from the last successful read
//   req_status            00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT
// ---------------------------------------------------------------------------
module wb_dsp_master_if #(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i,
    input  logic          req_start,
    input  logic          req_we,
    input  logic [aw-1:0] req_adr,
    input  logic [dw-1:0] req_dat,
    input  logic [3:0]    req_sel,
    output logic          req_busy,
    output logic          req_done,
    output logic [dw-1:0] req_rdata,
    output logic [1:0]    req_status
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int GW = (RETRY_GAP < 2) ? 1 : $clog2(RETRY_GAP + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(RETRY_GAP);
    // Last count value before abort; only meaningful when TIMEOUT != 0.
    localparam logic [TW-1:0] TMO_LAST   = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_ERR  = 2'b01;
    localparam logic [1:0] ST_RTY  = 2'b10;
    localparam logic [1:0] ST_TMO  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [RW-1:0]   retry_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [TW-1:0]   tmo_cnt;

    // Classic single transfers only.
    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state      <= S_IDLE;
            retry_cnt  <= '0;
            gap_cnt    <= '0;
            tmo_cnt    <= '0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            req_busy   <= 1'b0;
            req_done   <= 1'b0;
            req_rdata  <= '0;
            req_status <= '0;
        end else begin
            req_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_start) begin
                        wb_adr_o  <= req_adr;
                        wb_dat_o  <= req_dat;
                        wb_sel_o  <= req_sel;
                        wb_we_o   <= req_we;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        retry_cnt <= '0;
                        tmo_cnt   <= '0;
                        req_busy  <= 1'b1;
                        state     <= S_BUS;
                    end
                end

                S_BUS: begin
                    // Termination priority: err > rty > ack.
                    if (wb_err_i) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        req_done   <= 1'b1;
                        req_status <= ST_ERR;
                        req_busy   <= 1'b0;
                        state      <= S_IDLE;
                    end else if (wb_rty_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (retry_cnt == RETRY_LAST) begin
                            req_done   <= 1'b1;
                            req_status <= ST_RTY;
                            req_busy   <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            retry_cnt <= retry_cnt + RW'(1);
                            gap_cnt   <= GAP_LOAD;
                            state     <= S_GAP;
                        end
                    end else if (wb_ack_i) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        req_done   <= 1'b1;
                        req_status <= ST_OK;
                        req_busy   <= 1'b0;
                        state      <= S_IDLE;
                        if (!wb_we_o) begin
                            req_rdata <= wb_dat_i;
                        end
                    end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
                        // Reached on the TIMEOUT-th cycle of cyc/stb high.
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        req_done   <= 1'b1;
                        req_status <= ST_TMO;
                        req_busy   <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                S_GAP: begin
                    // Loaded with RETRY_GAP, so the bus stays low for exactly
                    // RETRY_GAP cycles before the reissue.
                    if (gap_cnt == GW'(1)) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= S_BUS;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end

                default: begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    req_busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_dsp_master_if.md
Name: wb_dsp_master_if

Overview:
Single-transfer Wishbone B3 classic master for the DSP core. It turns one-shot read/write requests from the DSP sequencer (equation fetch, operand load, result store) into Wishbone cycles on the system bus. It handles the ack/err/rty responses, bounded retry and a no-response timeout, and returns read data plus a completion status.

Parameters:
dw, 32, Wishbone data width
aw, 32, Wishbone address width
MAX_RETRY, 3, number of reissues allowed after wb_rty_i before giving up
RETRY_GAP, 4, idle cycles between a rty termination and the reissue (min 1)
TIMEOUT, 255, cycles with cyc/stb high and no response before abort; 0 disables

Ports:
wb_clk  in  1  clock
wb_rst  in  1  reset, asynchronous, active-high
wb_adr_o  out  aw  bus address
wb_dat_o  out  dw  write data
wb_sel_o  out  4  byte selects
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  cycle type, constant 3'b000
wb_bte_o  out  2  burst type, constant 2'b00
wb_dat_i  in  dw  read data
wb_ack_i  in  1  normal termination
wb_err_i  in  1  error termination
wb_rty_i  in  1  retry termination
req_start  in  1  one-cycle request strobe
req_we  in  1  1 = write, 0 = read
req_adr  in  aw  request address
req_dat  in  dw  request write data
req_sel  in  4  request byte selects
req_busy  out  1  transaction in progress
req_done  out  1  one-cycle completion pulse
req_rdata  out  dw  last successful read data
req_status  out  2  00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT

Behaviour:
- Reset: the asynchronous reset forces every output to 0 (wb_* outputs, req_busy, req_done, req_rdata, req_status), clears the counters and puts the FSM in IDLE. Asserting reset mid-transaction drops cyc/stb immediately; no req_done is generated.
- FSM states: IDLE, BUS, GAP. All outputs are registered.
- IDLE: on req_start, latch req_adr, req_dat, req_sel and req_we into wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o. Assert cyc/stb on the next edge (1-cycle latency), clear retry_cnt and tmo_cnt, and go to BUS.
- req_busy = (state != IDLE). A req_start while busy is ignored: it is not queued and has no effect.
- BUS: adr, dat, sel and we are held stable. Termination is sampled each cycle with priority err > rty > ack.
  - ack: cyc/stb=0 on the next edge, req_done=1, req_status=00, go to IDLE. If it was a read, req_rdata <= wb_dat_i.
  - err: cyc/stb=0, req_done=1, req_status=01, go to IDLE. req_rdata is unchanged.
  - rty with retry_cnt < MAX_RETRY: cyc/stb=0, retry_cnt++, load gap_cnt=RETRY_GAP, go to GAP.
  - rty with retry_cnt == MAX_RETRY: cyc/stb=0, req_done=1, req_status=10, go to IDLE.
  - No response: tmo_cnt++. When TIMEOUT != 0 and tmo_cnt reaches TIMEOUT-1 with no response on that cycle, set cyc/stb=0, req_done=1, req_status=11 and go to IDLE. cyc/stb is therefore high for exactly TIMEOUT cycles.
- GAP: cyc/stb stay low and gap_cnt decrements. At 1, cyc/stb reassert on the next edge with the same latched address, data, sel and we; tmo_cnt is cleared and the FSM goes to BUS.
- req_done is high for exactly one cycle, the cycle in which cyc/stb is first low again. That cycle is already IDLE, so a req_start there is accepted. Back-to-back transfers therefore have exactly one idle bus cycle between them.
- req_rdata and req_status hold their values until the next completion. A write completion never alters req_rdata.
- Any ack, err or rty arriving while in IDLE or GAP is ignored.
- cti and bte are tied to classic/linear; no bursts are issued.

Test Plan:
- Write: req_start, we=1, adr=0x100, dat=0xDEADBEEF, sel=0xF. The slave acks on the 2nd bus cycle. Required: cyc/stb high 2 cycles with those values, then req_done pulse, status=00, req_rdata unchanged.
- Read: adr=0x104, slave returns 0x12345678 with ack. Required: req_rdata=0x12345678 and status=00 in the done cycle. A req_start in the done cycle restarts after exactly one idle bus cycle.
- Error: slave asserts err and ack together. Required: status=01, req_rdata unchanged, one req_done.
- Retry: slave returns rty twice, then ack. Required: 3 bus attempts with identical adr/dat, each separated by 4 low cycles, status=00. With rty on every attempt, 4 attempts total, then status=10.
- Timeout: TIMEOUT=8 with a silent slave. Required: cyc/stb high exactly 8 cycles, then status=11 and req_done.
- Robustness: req_start while busy is ignored (no second cycle issued). Reset asserted mid-BUS drops cyc/stb asynchronously with no req_done. A stray ack in IDLE has no effect.
